dec_strobe_gen: RTL and testbench

//   Parametrised, registered N-to-2^N decoder that drives a one-hot strobe for a programmable hold time.

---
 rtl/dec_pkg.sv | 18 +
 rtl/dec_hold_cnt.sv | 30 +++
 rtl/dec_strobe_gen.sv | 116 +++++++++++
 tb/tb_dec_strobe_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered strobe decoder.
package dec_pkg;

  typedef enum logic {IDLE, ACTIVE} dec_state_t;

  localparam int DEC_HOLD_MIN  = 1;
  localparam int DEC_MAX_IN_W  = 8;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

  // Wide enough for any supported select width; callers cast down to their own OUT_W.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot(input logic [DEC_MAX_IN_W-1:0] sel);
    logic [DEC_MAX_OUT_W-1:0] r;
    r = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Hold-time down-counter for the strobe decoder: load, decrement, and cnt==1 flag.
module dec_hold_cnt #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              dec,
  input  logic [HOLD_W-1:0] load_val,
  output logic [HOLD_W-1:0] cnt,
  output logic              is_one
);

  // Abort has priority over a reload; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - HOLD_W'(1);
    end
  end

  assign is_one = (cnt == HOLD_W'(1));

endmodule

// File: rtl/dec_strobe_gen.sv
// Registered N-to-2^N decoder driving a one-hot strobe for a programmable hold time.
// Optional even-parity check on requests is enabled with `define DEC_PARITY_EN.
module dec_strobe_gen
  import dec_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int HOLD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_sel,
  input  logic [HOLD_W-1:0]    in_hold,
`ifdef DEC_PARITY_EN
  input  logic                 in_par,
  output logic                 err,
`endif
  output logic [2**IN_W-1:0]   out,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_W = 2**IN_W;

  dec_state_t        state;
  logic [HOLD_W-1:0] cnt;
  logic              is_one;
  logic              accept;
  logic              par_ok;
  logic              strobe;
  logic [HOLD_W-1:0] hold_eff;
  logic [OUT_W-1:0]  hot;

  assign in_ready = en & ((state == IDLE) | ((state == ACTIVE) & is_one));
  assign accept   = in_valid & in_ready;
  assign strobe   = accept & par_ok;
  assign hold_eff = (in_hold == '0) ? HOLD_W'(DEC_HOLD_MIN) : in_hold;
  assign hot      = OUT_W'(onehot(DEC_MAX_IN_W'(in_sel)));

`ifdef DEC_PARITY_EN
  assign par_ok = ~^{in_sel, in_hold, in_par};

  // Sticky until reset: a bad request is still handshaked, only the strobe is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && !par_ok) begin
      err <= 1'b1;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  dec_hold_cnt #(.HOLD_W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      ((state == ACTIVE) & ~en),
    .load     (strobe),
    .dec      ((state == ACTIVE) & en),
    .load_val (hold_eff),
    .cnt      (cnt),
    .is_one   (is_one)
  );

  // done is registered one cycle early so it is high exactly while cnt==1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (strobe) begin
            state <= ACTIVE;
            out   <= hot;
            busy  <= 1'b1;
            done  <= (hold_eff == HOLD_W'(1));
          end
        end
        ACTIVE: begin
          if (!en) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (is_one) begin
            if (strobe) begin
              out  <= hot;
              done <= (hold_eff == HOLD_W'(1));
            end else begin
              state <= IDLE;
              out   <= '0;
              busy  <= 1'b0;
              done  <= 1'b0;
            end
          end else begin
            done <= (cnt == HOLD_W'(2));
          end
        end
        default: begin
          state <= IDLE;
          out   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_strobe_gen.sv
// Directed self-checking bench for dec_strobe_gen; parity cases run when DEC_PARITY_EN is defined.
module tb_dec_strobe_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_par = 1'b0;
  logic [2:0] in_sel = '0;
  logic [3:0] in_hold = '0;
  logic       in_ready;
  logic [7:0] out;
  logic       busy;
  logic       done;
`ifdef DEC_PARITY_EN
  logic       err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_strobe_gen #(.IN_W(3), .HOLD_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_hold  (in_hold),
`ifdef DEC_PARITY_EN
    .in_par   (in_par),
    .err      (err),
`endif
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bad=1 deliberately corrupts the even parity bit.
  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [3:0] h, input logic bad);
    in_valid = v;
    in_sel   = s;
    in_hold  = h;
    in_par   = (^{s, h}) ^ bad;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] eo, input logic eb, input logic ed);
    checkOutput({tag, ".out"}, 32'(out), 32'(eo));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(eb));
    checkOutput({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    // Reset state
    #12;
    checkState("reset", 8'h00, 1'b0, 1'b0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // 1: sel=5 hold=2
    applyStimulus(1'b1, 3'd5, 4'd2, 1'b0);
    checkOutput("t1.ready_idle", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t1.c1", 8'h20, 1'b1, 1'b0);
    checkOutput("t1.ready_c1", 32'(in_ready), 32'd0);
    tick();
    checkState("t1.c2", 8'h20, 1'b1, 1'b1);
    checkOutput("t1.ready_c2", 32'(in_ready), 32'd1);
    tick();
    checkState("t1.end", 8'h00, 1'b0, 1'b0);

    // 2: hold=0 behaves as 1
    applyStimulus(1'b1, 3'd0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t2.c1", 8'h01, 1'b1, 1'b1);
    checkOutput("t2.ready", 32'(in_ready), 32'd1);
    tick();
    checkState("t2.end", 8'h00, 1'b0, 1'b0);

    // 3: back-to-back sel=1 hold=3 then sel=7 hold=1
    applyStimulus(1'b1, 3'd1, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t3.c1", 8'h02, 1'b1, 1'b0);
    tick();
    checkState("t3.c2", 8'h02, 1'b1, 1'b0);
    tick();
    checkState("t3.c3", 8'h02, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'd7, 4'd1, 1'b0);
    checkOutput("t3.ready_b2b", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t3.c4", 8'h80, 1'b1, 1'b1);
    tick();
    checkState("t3.end", 8'h00, 1'b0, 1'b0);

    // 4: abort after 3 active cycles, then en low in IDLE ignores requests
    applyStimulus(1'b1, 3'd4, 4'd15, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t4.c1", 8'h10, 1'b1, 1'b0);
    tick();
    tick();
    checkState("t4.c3", 8'h10, 1'b1, 1'b0);
    en = 1'b0;
    #1;
    checkOutput("t4.ready_en0", 32'(in_ready), 32'd0);
    tick();
    checkState("t4.abort", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 4'd1, 1'b0);
    checkOutput("t4.ready_idle_en0", 32'(in_ready), 32'd0);
    tick();
    checkState("t4.ignored", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    en = 1'b1;
    tick();

    // 5: async reset mid-strobe
    applyStimulus(1'b1, 3'd6, 4'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t5.c1", 8'h40, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkState("t5.async", 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd3, 4'd1, 1'b0);
    checkOutput("t5.ready_after", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t5.resume", 8'h08, 1'b1, 1'b1);
    tick();
    checkState("t5.end", 8'h00, 1'b0, 1'b0);

    // Sweep all selects back-to-back with hold=1
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b1, 3'(s), 4'd1, 1'b0);
      tick();
      checkOutput($sformatf("sweep.out%0d", s), 32'(out), 32'd1 << s);
    end
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    tick();
    checkState("sweep.end", 8'h00, 1'b0, 1'b0);

`ifdef DEC_PARITY_EN
    // 6: bad parity is consumed and dropped, err sticks
    checkOutput("t6.err_clear", 32'(err), 32'd0);
    applyStimulus(1'b1, 3'd2, 4'd1, 1'b1);
    checkOutput("t6.ready_bad", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t6.dropped", 8'h00, 1'b0, 1'b0);
    checkOutput("t6.err_set", 32'(err), 32'd1);
    applyStimulus(1'b1, 3'd2, 4'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkState("t6.good", 8'h04, 1'b1, 1'b1);
    checkOutput("t6.err_sticky", 32'(err), 32'd1);
    tick();
    checkState("t6.end", 8'h00, 1'b0, 1'b0);
    checkOutput("t6.err_sticky2", 32'(err), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
